// File: rtl/mem_access_unit_pkg.sv
// Shared memory-access definitions: size encodings and access FSM state codes.
// Used by the access unit, the data RAM and the CPU control.
package mem_defs;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Offset of the last byte touched by an access of the given size.
   function automatic logic [1:0] size_extra(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 2'd0;
         SZ_HALF: return 2'd1;
         SZ_WORD: return 2'd3;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response and data-RAM signal bundle of the memory access unit.
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_exc;
   logic [31:0] resp_badvaddr;

   logic        ram_we;
   logic [31:0] ram_addr;
   logic [1:0]  ram_mask;
   logic        ram_signed_ext;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   // CPU + RAM side
   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output resp_ready, ram_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_exc, resp_badvaddr,
      input  ram_we, ram_addr, ram_mask, ram_signed_ext, ram_wdata
   );

   // Access unit side
   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  resp_ready, ram_rdata,
      output req_ready, resp_valid, resp_rdata, resp_exc, resp_badvaddr,
      output ram_we, ram_addr, ram_mask, ram_signed_ext, ram_wdata
   );

endinterface

// File: rtl/mem_access_unit_align_check.sv
// Address fault detection: misalignment (optional) and out-of-range accesses.
module mem_align_check
   import mem_defs::*;
#(
   parameter int MEM_BYTES   = 1024,
   parameter int CHECK_ALIGN = 1
) (
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   output logic        fault
);

   logic [32:0] last_byte;
   logic        misaligned;

   // Flag accesses that are misaligned or whose last byte falls outside the RAM.
   always_comb begin
      misaligned = 1'b0;
      if (CHECK_ALIGN != 0) begin
         if (size == SZ_HALF) begin
            misaligned = addr[0];
         end else if (size[1]) begin
            misaligned = (addr[1:0] != 2'b00);
         end
      end
      // 33 bits so an access near 0xFFFFFFFF cannot wrap back into range
      last_byte = {1'b0, addr} + {31'b0, size_extra(size)};
      fault     = misaligned || (last_byte >= 33'(MEM_BYTES));
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: accepts one CPU load/store at a time, checks it for
// address faults, performs a single-cycle RAM access and holds the response
// until the CPU takes it.
module mem_access_unit
   import mem_defs::*;
#(
   parameter int MEM_BYTES   = 1024,
   parameter int CHECK_ALIGN = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_access_unit_if.slave bus
);

   state_t      state;
   state_t      next_state;
   logic        fault;
   logic        accept;

   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_signed;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic [31:0] rdata_q;
   logic        exc_q;
   logic [31:0] badvaddr_q;

   mem_align_check #(
      .MEM_BYTES   (MEM_BYTES),
      .CHECK_ALIGN (CHECK_ALIGN)
   ) u_align (
      .addr  (bus.req_addr),
      .size  (bus.req_size),
      .fault (fault)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and state-decoded handshake/RAM strobe.
   always_comb begin
      next_state     = state;
      accept         = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.ram_we     = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept     = 1'b1;
               next_state = fault ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            bus.ram_we = lat_we;
            next_state = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Request latch and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we     <= 1'b0;
         lat_size   <= '0;
         lat_signed <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata_q    <= '0;
         exc_q      <= 1'b0;
         badvaddr_q <= '0;
      end else if (accept) begin
         lat_we     <= bus.req_we;
         lat_size   <= bus.req_size;
         lat_signed <= bus.req_signed;
         lat_addr   <= bus.req_addr;
         lat_wdata  <= bus.req_wdata;
         rdata_q    <= '0;
         exc_q      <= fault;
         badvaddr_q <= fault ? bus.req_addr : '0;
      end else if (state == ACCESS) begin
         rdata_q <= lat_we ? '0 : bus.ram_rdata;
      end
   end

   assign bus.ram_addr       = lat_addr;
   assign bus.ram_mask       = lat_size;
   assign bus.ram_signed_ext = lat_signed;
   assign bus.ram_wdata      = lat_wdata;

   assign bus.resp_rdata     = rdata_q;
   assign bus.resp_exc       = exc_q;
   assign bus.resp_badvaddr  = badvaddr_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, giving the byte size of the attached data RAM; addresses >= MEM_BYTES are out of range.
REQ-002 SHALL have parameter CHECK_ALIGN, default 1; 1 enables alignment exceptions, 0 passes misaligned accesses to the RAM.
REQ-003 Ports, clock and reset first:
 clk  in  1  single clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 req_valid  in  1  CPU request present
 req_ready  out  1  unit can accept a request
 req_we  in  1  1 = store, 0 = load
 req_size  in  2  00 byte, 01 half, 1x word
 req_signed  in  1  sign-extend load data
 req_addr  in  32  byte address
 req_wdata  in  32  store data, right-aligned
 resp_valid  out  1  response available
 resp_ready  in  1  CPU takes response
 resp_rdata  out  32  load data, extended; 0 for stores and exceptions
 resp_exc  out  1  address error
 resp_badvaddr  out  32  faulting address, 0 otherwise
 ram_we  out  1  RAM write enable
 ram_addr  out  32  RAM byte address
 ram_mask  out  2  RAM size (same encoding as req_size)
 ram_signed_ext  out  1  RAM sign-extend select
 ram_wdata  out  32  RAM write data
 ram_rdata  in  32  RAM combinational read data

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-005 IDLE: req_ready=1; on req_valid, SHALL latch we/size/signed/addr/wdata at the edge.
REQ-006 At accept, the request SHALL be faulting if (CHECK_ALIGN and size=01 and addr[0]) or (CHECK_ALIGN and size=1x and addr[1:0]!=0) or addr+bytes-1 >= MEM_BYTES.
REQ-007 Faulting request: IDLE->RESP directly, resp_exc=1, resp_badvaddr=addr, resp_rdata=0, ram_we never asserted.
REQ-008 Non-faulting request: IDLE->ACCESS; in ACCESS, ram_addr/mask/signed_ext/wdata SHALL equal the latched fields and ram_we SHALL equal latched we for exactly that one cycle.
REQ-009 ACCESS: loads SHALL capture ram_rdata into resp_rdata at the closing edge; stores SHALL set resp_rdata=0; then ACCESS->RESP.
REQ-010 RESP: resp_valid=1; resp_rdata, resp_exc, resp_badvaddr SHALL stay stable until resp_ready=1 is sampled, then RESP->IDLE.
REQ-011 req_ready SHALL be 0 in ACCESS and RESP; requests are not queued.
REQ-012 Latency: non-faulting response valid 2 cycles after the accept edge, faulting 1 cycle; peak throughput 1 request per 3 cycles.
REQ-013 Outside ACCESS, ram_we SHALL be 0; other ram_* outputs hold the latched values.
REQ-014 ram_we SHALL be decoded from the state register only, never from req_* inputs.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE and clear all latched fields and response registers; all outputs 0 except req_ready=1.
REQ-016 Reset during ACCESS SHALL drop ram_we immediately; a store whose ACCESS edge coincides with rst_n low SHALL NOT be written. A pending response is discarded.

Structure
REQ-017 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state codes SHALL be in the shared package mem_defs, also used by the RAM and the CPU control.
REQ-018 Fault detection SHALL be one combinational sub-module, mem_align_check (addr, size -> fault).

Verification
REQ-019 Store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata=0xDEADBEEF, resp_exc=0, resp_valid 2 cycles after accept.
REQ-020 Store byte 0x80 @0x21; signed byte load @0x21 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-021 Load half @0x33 -> resp_exc=1, resp_badvaddr=0x33, resp_rdata=0, ram_we 0 throughout, resp_valid 1 cycle after accept.
REQ-022 Store word @0x3FE with MEM_BYTES=1024 -> resp_exc=1 (range), RAM contents unchanged.
REQ-023 Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=0, new req_valid ignored; response consumed on cycle 6.
REQ-024 Assert rst_n=0 during ACCESS of store 0x12345678 @0x40 -> IDLE, req_ready=1, subsequent load @0x40 returns the prior value.
